// File: rtl/sprite_table.sv
// Double-buffered sprite descriptor table: the Avalon slave writes shadow slots,
// and an armed commit copies them into the active table at vblank start.
module sprite_table #(
  parameter int unsigned NUM_SPRITES = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic                      read,
  input  logic [4:0]                address,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [9:0]                VGA_HCOUNT,
  input  logic [9:0]                VGA_VCOUNT,
  output logic [NUM_SPRITES*32-1:0] sprites,
  output logic                      commit_done
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FRAME_W = 8;
  localparam logic [9:0]  VBLANK_LINE = 10'd480;
  localparam logic [4:0]  CTRL_ADDR   = 5'd30;
  localparam logic [4:0]  STAT_ADDR   = 5'd31;

  logic [WORD_W-1:0]  shadow [NUM_SPRITES];
  logic [WORD_W-1:0]  active [NUM_SPRITES];
  logic               pending;
  logic [FRAME_W-1:0] frame_count;
  logic [9:0]         prev_vcount;

  logic              wr_en_c;
  logic              rd_en_c;
  logic              vblank_start_c;
  logic              commit_c;
  logic              arm_c;
  logic [WORD_W-1:0] rd_word_c;
  logic              unused_hcount;

  // Horizontal position is not needed to locate the frame boundary.
  assign unused_hcount = ^VGA_HCOUNT;

  // Bus qualification and frame-boundary detection.
  always_comb begin
    wr_en_c        = chipselect && write;
    rd_en_c        = chipselect && read;
    vblank_start_c = (VGA_VCOUNT == VBLANK_LINE) && (prev_vcount != VBLANK_LINE);
    commit_c       = vblank_start_c && pending;
    arm_c          = wr_en_c && (address == CTRL_ADDR) && writedata[0];
  end

  // Read mux; the control word and unmapped addresses read as zero.
  always_comb begin
    rd_word_c = '0;
    if (address == STAT_ADDR) begin
      rd_word_c = {16'b0, frame_count, 7'b0, pending};
    end else begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (address == 5'(i)) rd_word_c = shadow[i];
      end
    end
  end

  // Shadow and active tables; the commit samples shadow before any same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (wr_en_c && (address == 5'(i)))
          shadow[i] <= (writedata[31:25] == 7'd0) ? '0 : writedata;
        if (commit_c)
          active[i] <= shadow[i];
      end
    end
  end

  // Commit arming, frame counting and bus read register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      frame_count <= '0;
      prev_vcount <= '0;
      readdata    <= '0;
      commit_done <= 1'b0;
    end else begin
      prev_vcount <= VGA_VCOUNT;
      commit_done <= commit_c;
      if (arm_c)
        pending <= 1'b1;
      else if (commit_c)
        pending <= 1'b0;
      if (vblank_start_c)
        frame_count <= frame_count + FRAME_W'(1);
      if (rd_en_c)
        readdata <= rd_word_c;
    end
  end

  for (genvar k = 0; k < int'(NUM_SPRITES); k++) begin : g_pack
    assign sprites[32*k +: 32] = active[k];
  end

endmodule

// File: tb/tb_sprite_table.sv
// Directed bench for sprite_table: bus access, vblank commit, frame counter and reset.
module tb_sprite_table;

  localparam int unsigned N = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            chipselect;
  logic            write;
  logic            read;
  logic [4:0]      address;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic [9:0]      hcount;
  logic [9:0]      vcount;
  logic [N*32-1:0] sprites;
  logic            commit_done;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_table #(.NUM_SPRITES(N)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_HCOUNT(hcount), .VGA_VCOUNT(vcount), .sprites(sprites),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    idle_bus();
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    idle_bus();
    d = readdata;
  endtask

  function automatic logic [31:0] slot(input int k);
    return sprites[32*k +: 32];
  endfunction

  // One short frame: the 479 -> 480 step is the vblank start.
  task automatic frame();
    vcount = 10'd479; tick();
    vcount = 10'd480; tick();
    vcount = 10'd0;   tick();
  endtask

  logic [31:0] rd;
  int pulses;

  initial begin
    reset = 1'b1; idle_bus(); address = '0; writedata = '0;
    hcount = 10'd100; vcount = 10'd0;
    tick(); tick();
    check("reset_slot0", slot(0), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_commit_done", {31'b0, commit_done}, 32'h0);
    reset = 1'b0;
    tick();

    // Basic armed commit
    bus_write(5'd0, 32'h0A0A_1414);
    check("no_commit_on_write", slot(0), 32'h0);
    bus_write(5'd30, 32'h1);
    bus_read(5'd31, rd);
    check("status_armed", rd, 32'h0000_0001);
    vcount = 10'd479; tick();
    check("slot0_before_vblank", slot(0), 32'h0);
    vcount = 10'd480; tick();
    check("slot0_committed", slot(0), 32'h0A0A_1414);
    check("commit_done_pulse", {31'b0, commit_done}, 32'h1);
    tick();
    check("commit_done_single", {31'b0, commit_done}, 32'h0);
    vcount = 10'd0; tick();
    bus_read(5'd31, rd);
    check("status_after_commit", rd, 32'h0000_0100);

    // Unarmed frame
    bus_write(5'd3, 32'h1234_5678);
    vcount = 10'd479; tick();
    vcount = 10'd480; tick();
    check("unarmed_no_pulse", {31'b0, commit_done}, 32'h0);
    vcount = 10'd0; tick();
    check("unarmed_slot3", slot(3), 32'h0);
    bus_read(5'd31, rd);
    check("unarmed_frame_count", rd, 32'h0000_0200);

    // Zero-dim write and address map reads
    bus_write(5'd1, 32'h0000_1234);
    bus_read(5'd1, rd);
    check("zero_dim_disabled", rd, 32'h0);
    bus_read(5'd3, rd);
    check("shadow_slot3", rd, 32'h1234_5678);
    tick();
    check("readdata_holds", readdata, 32'h1234_5678);
    bus_read(5'd25, rd);
    check("unmapped_read", rd, 32'h0);
    bus_read(5'd30, rd);
    check("control_read", rd, 32'h0);
    bus_write(5'd30, 32'h0);
    bus_read(5'd31, rd);
    check("arm_zero_ignored", rd, 32'h0000_0200);

    // VCOUNT held at 480: one commit, one frame increment
    bus_write(5'd4, 32'hFE00_0001);
    bus_write(5'd30, 32'h1);
    vcount = 10'd479; tick();
    vcount = 10'd480;
    pulses = 0;
    repeat (800) begin tick(); pulses += int'(commit_done); end
    check("hold480_pulses", 32'(pulses), 32'd1);
    check("hold480_slot4", slot(4), 32'hFE00_0001);
    vcount = 10'd0; tick();
    bus_read(5'd31, rd);
    check("hold480_status", rd, 32'h0000_0300);

    // Shadow write coinciding with commit
    bus_write(5'd2, 32'h0200_0002);
    bus_write(5'd30, 32'h1);
    frame();
    check("slot2_old", slot(2), 32'h0200_0002);
    bus_write(5'd30, 32'h1);
    vcount = 10'd479; tick();
    vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1; address = 5'd2; writedata = 32'h0400_0004;
    tick(); idle_bus();
    check("coincide_commit", {31'b0, commit_done}, 32'h1);
    check("coincide_active_old", slot(2), 32'h0200_0002);
    vcount = 10'd0; tick();
    bus_read(5'd2, rd);
    check("coincide_shadow_new", rd, 32'h0400_0004);

    // Arm in vblank-start cycle with nothing pending: no commit, pending set
    vcount = 10'd479; tick();
    vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1; address = 5'd30; writedata = 32'h1;
    tick(); idle_bus();
    check("arm_vblank_no_pulse", {31'b0, commit_done}, 32'h0);
    check("arm_vblank_slot2_old", slot(2), 32'h0200_0002);
    vcount = 10'd0; tick();
    bus_read(5'd31, rd);
    check("arm_vblank_status", rd, 32'h0000_0601);
    frame();
    check("next_frame_slot2_new", slot(2), 32'h0400_0004);
    bus_read(5'd31, rd);
    check("next_frame_status", rd, 32'h0000_0700);

    // Arm coinciding with commit keeps pending
    bus_write(5'd30, 32'h1);
    vcount = 10'd479; tick();
    vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1; address = 5'd30; writedata = 32'h1;
    tick(); idle_bus();
    check("rearm_commit", {31'b0, commit_done}, 32'h1);
    vcount = 10'd0; tick();
    bus_read(5'd31, rd);
    check("rearm_pending", rd, 32'h0000_0801);

    // Status read in the commit cycle returns pre-edge values
    vcount = 10'd479; tick();
    vcount = 10'd480;
    chipselect = 1'b1; read = 1'b1; address = 5'd31;
    tick(); idle_bus();
    check("status_in_commit", readdata, 32'h0000_0801);
    check("status_commit_pulse", {31'b0, commit_done}, 32'h1);
    vcount = 10'd0; tick();
    bus_read(5'd31, rd);
    check("status_post_commit", rd, 32'h0000_0900);

    // Frame counter wrap
    repeat (246) frame();
    bus_read(5'd31, rd);
    check("frame_count_255", rd, 32'h0000_FF00);
    frame();
    bus_read(5'd31, rd);
    check("frame_count_wrap", rd, 32'h0000_0000);

    // Mid-cycle reset with a pending commit
    bus_write(5'd5, 32'h0C00_0005);
    bus_write(5'd30, 32'h1);
    bus_read(5'd31, rd);
    check("pre_reset_pending", rd, 32'h0000_0001);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < int'(N); k++) check($sformatf("reset_async_slot%0d", k), slot(k), 32'h0);
    check("reset_async_readdata", readdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    bus_read(5'd31, rd);
    check("reset_pending_cleared", rd, 32'h0);
    bus_read(5'd5, rd);
    check("reset_shadow_cleared", rd, 32'h0);
    bus_write(5'd6, 32'h0600_0006);
    vcount = 10'd479; tick();
    vcount = 10'd480; tick();
    check("post_reset_no_pulse", {31'b0, commit_done}, 32'h0);
    vcount = 10'd0; tick();
    check("post_reset_no_commit", slot(6), 32'h0);
    bus_read(5'd31, rd);
    check("post_reset_frame", rd, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
